// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Sequential 8-bit signed divider built on a restoring, one-bit-per-cycle
//   core. It works on operand magnitudes and applies the signs afterwards, so
//   the quotient truncates toward zero and the remainder takes the sign of the
//   dividend.
//
//   Timing of an accepted start (edge E0):
//     b != 0 : CALC on E1..E8, FIX on E9, done in the 10th cycle after E0.
//     b == 0 : straight to DONE; done in the cycle after E0.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   start  in   request pulse, sampled only in IDLE
//   a      in   [7:0] signed dividend, captured on the accepted start edge
//   b      in   [7:0] signed divisor, captured on the accepted start edge
//   quot   out  [7:0] signed quotient (registered)
//   rem    out  [7:0] signed remainder (registered)
//   busy   out  high in CALC and FIX
//   done   out  one-cycle pulse; results are valid from this cycle onward
//   dbz    out  divide-by-zero flag (registered)
//   ovf    out  quotient overflow flag, set only for -128 / -1 (registered)
// ----------------------------------------------------------------------------
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] quot,
    output logic [7:0] rem,
    output logic       busy,
    output logic       done,
    output logic       dbz,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_next;

    logic [7:0]  b_mag;      // |b|
    logic        a_neg;      // sign of the captured dividend
    logic        b_neg;      // sign of the captured divisor
    logic        ovf_pend;   // -128 / -1 seen at capture, published in FIX
    logic [3:0]  cnt;        // restoring-step counter
    logic [8:0]  r_part;     // partial remainder
    logic [7:0]  q_part;     // quotient bits; starts out holding |a|

    // Magnitudes of the live inputs. |-128| = 0x80 still fits as unsigned.
    logic [7:0]  a_abs, b_abs;
    assign a_abs = a[7] ? 8'(~a + 8'd1) : a;
    assign b_abs = b[7] ? 8'(~b + 8'd1) : b;

    // One restoring step: shift {R,Q} left, trial-subtract |b|.
    logic [8:0]  r_shift, r_sub;
    logic        r_ge;
    assign r_shift = {r_part[7:0], q_part[7]};
    assign r_ge    = (r_shift >= {1'b0, b_mag});
    assign r_sub   = r_shift - {1'b0, b_mag};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = (b == 8'd0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == 4'd7) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Results only change on the FIX edge or on a divide-by-zero
    // acceptance, so they hold steady between operations.
    // NOTE: the datapath is reset along with the FSM; it is a handful of flops,
    // not a memory, and the outputs must read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_mag    <= 8'd0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            ovf_pend <= 1'b0;
            cnt      <= 4'd0;
            r_part   <= 9'd0;
            q_part   <= 8'd0;
            quot     <= 8'd0;
            rem      <= 8'd0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (b == 8'd0) begin
                            quot <= 8'd0;
                            rem  <= a;
                            dbz  <= 1'b1;
                            ovf  <= 1'b0;
                        end else begin
                            b_mag    <= b_abs;
                            a_neg    <= a[7];
                            b_neg    <= b[7];
                            ovf_pend <= (a == 8'h80) && (b == 8'hFF);
                            cnt      <= 4'd0;
                            r_part   <= 9'd0;
                            q_part   <= a_abs;
                        end
                    end
                end
                CALC: begin
                    r_part <= r_ge ? r_sub : r_shift;
                    q_part <= {q_part[6:0], r_ge};
                    cnt    <= cnt + 4'd1;
                end
                FIX: begin
                    // -128 / -1 yields magnitude 128 with equal signs, which
                    // is already the required 0x80 pattern.
                    quot <= (a_neg ^ b_neg) ? 8'(-q_part) : q_part;
                    rem  <= a_neg ? 8'(-r_part[7:0]) : r_part[7:0];
                    dbz  <= 1'b0;
                    ovf  <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider. Expected results come from plain
//   signed integer arithmetic (truncating division and the remainder of the
//   dividend's sign), with the two exception cases spelled out separately.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic [7:0] quot, rem;
    logic       busy, done, dbz, ovf;

    seq_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .quot  (quot),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [17:0] prev_res = 18'd0;   // {quot, rem, dbz, ovf} last published
    logic [15:0] opq[$];             // operands accepted in streaming mode

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {quot, rem, dbz, ovf} for one operand pair.
    function automatic logic [17:0] model(input logic [7:0] av, input logic [7:0] bv);
        int ai;
        int bi;
        int q;
        int r;
        ai = $signed(av);
        bi = $signed(bv);
        if (bi == 0) return {8'h00, av, 1'b1, 1'b0};
        if (ai == -128 && bi == -1) return {8'h80, 8'h00, 1'b0, 1'b1};
        q = ai / bi;
        r = ai % bi;
        return {q[7:0], r[7:0], 2'b00};
    endfunction

    // One full operation; noise on start/a/b while the divider is busy.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
        logic [17:0] exp;
        exp   = model(av, bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        if (bv == 8'd0) begin
            a = 8'($urandom);
            check({tag, " dbz done"}, {busy, done, quot, rem, dbz, ovf}, {2'b01, exp});
        end else begin
            for (int c = 1; c <= 9; c++) begin
                check({tag, " busy"}, {busy, done, quot, rem, dbz, ovf}, {2'b10, prev_res});
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            check({tag, " done"}, {busy, done, quot, rem, dbz, ovf}, {2'b01, exp});
        end
        prev_res = exp;
        tick();
        check({tag, " hold"}, {busy, done, quot, rem, dbz, ovf}, {2'b00, prev_res});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        tick();
        start = 1'b1;                             // reset overrides start
        tick();
        check("reset", {busy, done, quot, rem, dbz, ovf}, 20'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // Directed cases.
        run_op(8'd100, 8'd7,  "100/7");
        run_op(-8'sd100, 8'd7,  "-100/7");
        run_op(8'd100, -8'sd7,  "100/-7");
        run_op(-8'sd100, -8'sd7, "-100/-7");
        run_op(8'h80, 8'hFF, "-128/-1");
        run_op(8'h80, 8'h01, "-128/1");
        run_op(8'd127, 8'h80, "127/-128");
        run_op(8'd5,   8'd0,  "5/0");
        run_op(8'd0,   8'hFF, "0/-1");

        // Random operands, roughly one in eight with a zero divisor.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] av, bv;
            av = 8'($urandom);
            bv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(av, bv, "random");
        end

        // start held high, operands changing every cycle: one result per 11.
        for (int k = 0; k < 32; k++) begin
            a     = 8'($urandom);
            b     = 8'($urandom_range(1, 255));
            start = 1'b1;
            if (k % 11 == 0) opq.push_back({a, b});
            tick();
            if (k % 11 == 9) begin
                logic [15:0] ops;
                ops      = opq.pop_front();
                prev_res = model(ops[15:8], ops[7:0]);
                check("stream done", {busy, done, quot, rem, dbz, ovf}, {2'b01, prev_res});
            end else begin
                check("stream ctrl", {busy, done}, (k % 11 < 9) ? 2'b10 : 2'b00);
            end
        end
        start = 1'b0;
        tick();
        check("stream idle", {busy, done, quot, rem, dbz, ovf}, {2'b00, prev_res});

        // Reset on the 4th CALC cycle.
        a     = 8'd50;
        b     = 8'd3;
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick();
        tick();
        tick();                                   // now in CALC cycle 4
        check("pre-reset busy", {busy, done}, 2'b10);
        rst = 1'b1;
        tick();
        check("mid reset", {busy, done, quot, rem, dbz, ovf}, 20'd0);
        rst      = 1'b0;
        prev_res = 18'd0;
        for (int c = 0; c < 12; c++) begin
            check("no done after reset", {busy, done}, 2'b00);
            tick();
        end
        run_op(8'd9, 8'd3, "9/3 after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 8 bits, two's complement, matching the coprocessor datapath.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  8  signed dividend; captured on the accepted start edge.
REQ-006 b  input  8  signed divisor; captured on the accepted start edge.
REQ-007 quot  output  8  signed quotient, registered.
REQ-008 rem  output  8  signed remainder, registered.
REQ-009 busy  output  1  high in CALC and FIX.
REQ-010 done  output  1  single-cycle pulse; results valid from this cycle onward.
REQ-011 dbz  output  1  divide-by-zero flag, registered.
REQ-012 ovf  output  1  quotient-overflow flag, registered.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1 and b!=0 at edge E0, the block SHALL capture |a| and |b| as 8-bit unsigned magnitudes, capture both operand signs, clear the 4-bit iteration counter, and go to CALC.
REQ-015 In IDLE with start=1 and b==0, the block SHALL go directly to DONE with quot=0x00, rem=a, dbz=1, ovf=0; done is high in the cycle after E0.
REQ-016 CALC SHALL perform one restoring step per cycle: shift {R,Q} left one bit; if R>=|b|, subtract |b| and set Q[0]=1. R is a 9-bit partial remainder.
REQ-017 CALC SHALL run exactly 8 cycles (edges E1..E8) and then go to FIX.
REQ-018 FIX (edge E9) SHALL negate Q when the operand signs differ and negate R when a<0, register quot and rem, and go to DONE.
REQ-019 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge; for nonzero b, done is high in the 10th cycle after E0.
REQ-020 Division SHALL truncate toward zero; rem SHALL take the sign of a (or be 0); a == quot*b + rem SHALL hold for all non-exception cases.
REQ-021 For a=-128 and b=-1, the block SHALL set ovf=1, quot=0x80 (the low 8 bits of +128), rem=0x00, with normal latency.
REQ-022 The block SHALL clear ovf=0 and dbz=0 for every other operand pair.
REQ-023 The block SHALL ignore start in CALC, FIX and DONE, and SHALL NOT re-sample a or b in those states.
REQ-024 Operand changes after E0 SHALL NOT affect the result.
REQ-025 The block SHALL hold quot, rem, dbz and ovf stable from done until the next accepted start completes its FIX or DONE update.
REQ-026 A back-to-back start SHALL be accepted at the earliest in the first IDLE cycle after DONE.

Reset
REQ-027 With rst=1 at a rising edge, the block SHALL enter IDLE and force quot=0, rem=0, busy=0, done=0, dbz=0, ovf=0, with the counter at 0.
REQ-028 rst SHALL override start and any in-progress operation; reset mid-CALC discards the operation and produces no done pulse.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 a=100, b=7, start pulse -> busy for 9 cycles, done in the 10th cycle, quot=14, rem=2, dbz=0, ovf=0.
REQ-031 Signs: -100/7 -> quot=-14, rem=-2; 100/-7 -> quot=-14, rem=2; -100/-7 -> quot=14, rem=-2.
REQ-032 a=-128, b=-1 -> quot=0x80, rem=0, ovf=1; a=-128, b=1 -> quot=-128, rem=0, ovf=0; a=127, b=-128 -> quot=0, rem=127.
REQ-033 a=5, b=0 -> done in the next cycle, dbz=1, quot=0, rem=5, busy never asserted.
REQ-034 start held high continuously with a changing every cycle -> one result per 11 cycles, each matching the operands captured at its acceptance edge.
REQ-035 rst asserted on the 4th CALC cycle -> all outputs 0 on the next cycle, no done pulse, next start (a=9, b=3) -> quot=3, rem=0.
